mandelbrot_iter_engine: RTL



---
 rtl/mandelbrot_iter_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel Mandelbrot escape-count engine: z <- z^2 + c, one iteration per clock, signed 2.(WIDTH-2) fixed point.
// Optional MANDEL_CYCLE_DETECT_EN: Brent-style periodicity check terminates in-set points early with identical results.
module mandelbrot_iter_engine #(
    parameter int WIDTH     = 8,
    parameter int ITER_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_cr,
    input  logic [WIDTH-1:0]     in_ci,
    input  logic [ITER_BITS-1:0] max_iter,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ITER_BITS-1:0] out_iter,
    output logic                 out_in_set
);
    localparam int W2 = 2 * WIDTH + 2;
    localparam int SH = WIDTH - 2;
    localparam logic signed [W2-1:0] ONE_W = W2'(1);
    localparam logic signed [W2-1:0] Z_MAX = (ONE_W <<< (WIDTH - 1)) - ONE_W;
    localparam logic signed [W2-1:0] Z_MIN = -(ONE_W <<< (WIDTH - 1));
    localparam logic signed [W2-1:0] SQ_LIM = ONE_W <<< (2 * WIDTH - 2);
    localparam logic [ITER_BITS:0] CNT_ONE = (ITER_BITS + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [ITER_BITS-1:0]    cnt_q, cnt_d, max_q, max_d, out_iter_q, out_iter_d;
    logic                    out_in_set_q, out_in_set_d;

    logic signed [W2-1:0]    zr_x, zi_x, cr_x, ci_x;
    logic signed [W2-1:0]    zr2, zi2, zrzi, sq, nzr, nzi;
    logic [ITER_BITS:0]      cnt1;
    logic                    esc, ovf, hit_lim, cyc_hit;

`ifdef MANDEL_CYCLE_DETECT_EN
    logic signed [WIDTH-1:0] zr_ref_q, zr_ref_d, zi_ref_q, zi_ref_d;
    logic                    pow2;
`endif

    always_comb begin
        zr_x    = W2'(zr_q);
        zi_x    = W2'(zi_q);
        cr_x    = W2'(cr_q);
        ci_x    = W2'(ci_q);
        zr2     = zr_x * zr_x;
        zi2     = zi_x * zi_x;
        zrzi    = zr_x * zi_x;
        sq      = zr2 + zi2;
        // Exactly 4.0 stays inside; only strictly greater escapes.
        esc     = sq > SQ_LIM;
        nzr     = ((zr2 - zi2) >>> SH) + cr_x;
        nzi     = ((zrzi <<< 1) >>> SH) + ci_x;
        ovf     = (nzr > Z_MAX) || (nzr < Z_MIN) || (nzi > Z_MAX) || (nzi < Z_MIN);
        cnt1    = {1'b0, cnt_q} + CNT_ONE;
        hit_lim = cnt1 == {1'b0, max_q};
    end

`ifdef MANDEL_CYCLE_DETECT_EN
    assign pow2    = (cnt1 & (cnt1 - CNT_ONE)) == '0;
    assign cyc_hit = (nzr[WIDTH-1:0] == zr_ref_q) && (nzi[WIDTH-1:0] == zi_ref_q);
`else
    assign cyc_hit = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE) && !reset;
    assign out_valid  = (state_q == DONE);
    assign out_iter   = out_iter_q;
    assign out_in_set = out_in_set_q;

    always_comb begin
        state_d      = state_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        cr_d         = cr_q;
        ci_d         = ci_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        out_iter_d   = out_iter_q;
        out_in_set_d = out_in_set_q;
`ifdef MANDEL_CYCLE_DETECT_EN
        zr_ref_d     = zr_ref_q;
        zi_ref_d     = zi_ref_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cr_d       = in_cr;
                    ci_d       = in_ci;
                    max_d      = max_iter;
                    zr_d       = '0;
                    zi_d       = '0;
                    cnt_d      = '0;
                    out_iter_d = '0;
`ifdef MANDEL_CYCLE_DETECT_EN
                    zr_ref_d   = '0;
                    zi_ref_d   = '0;
`endif
                    if (max_iter == '0) begin
                        state_d      = DONE;
                        out_in_set_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        out_in_set_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (esc || ovf) begin
                    state_d      = DONE;
                    out_iter_d   = cnt_q;
                    out_in_set_d = 1'b0;
                end else if (hit_lim || cyc_hit) begin
                    // A repeated orbit point can never escape, so report it as the limit.
                    state_d      = DONE;
                    out_iter_d   = max_q;
                    out_in_set_d = 1'b1;
                end else begin
                    zr_d  = nzr[WIDTH-1:0];
                    zi_d  = nzi[WIDTH-1:0];
                    cnt_d = cnt1[ITER_BITS-1:0];
`ifdef MANDEL_CYCLE_DETECT_EN
                    if (pow2) begin
                        zr_ref_d = nzr[WIDTH-1:0];
                        zi_ref_d = nzi[WIDTH-1:0];
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            zr_q         <= '0;
            zi_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            cnt_q        <= '0;
            max_q        <= '0;
            out_iter_q   <= '0;
            out_in_set_q <= 1'b0;
`ifdef MANDEL_CYCLE_DETECT_EN
            zr_ref_q     <= '0;
            zi_ref_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            out_iter_q   <= out_iter_d;
            out_in_set_q <= out_in_set_d;
`ifdef MANDEL_CYCLE_DETECT_EN
            zr_ref_q     <= zr_ref_d;
            zi_ref_q     <= zi_ref_d;
`endif
        end
    end
endmodule
